// File: rtl/uart_rx_if.sv
// uart_rx_if
//   Word-level handshake between the UART frame receiver and its consumer.
//   master : the receiver. It drives rx_data/rx_valid, the error pulses and busy,
//            and it samples rx_ack.
//   slave  : the consumer. It samples the word and the status, and it drives rx_ack.
//   Signals:
//     rx_data[15:0]  received word {byte0, byte1}
//     rx_valid       rx_data holds an unconsumed word
//     rx_ack         consumer accepts the word (only meaningful while rx_valid=1)
//     frame_err      1-cycle pulse, stop bit sampled low
//     timeout_err    1-cycle pulse, second byte did not start in time
//     overrun        1-cycle pulse, word completed while rx_valid was still set
//     busy           bit FSM active or first byte held
interface uart_rx_if;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ack;
    logic        frame_err;
    logic        timeout_err;
    logic        overrun;
    logic        busy;

    modport master (
        output rx_data, rx_valid, frame_err, timeout_err, overrun, busy,
        input  rx_ack
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, timeout_err, overrun, busy,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame
//   8N1 UART receiver. It pairs two consecutive bytes into one 16-bit word, with the
//   first byte as the high half, and presents the word through a valid/ack handshake.
//   It also reports framing errors, inter-byte timeouts and overruns.
//   Parameters:
//     CLKS_PER_BIT  clock cycles per bit (minimum 8)
//     TIMEOUT_BITS  bit times allowed between the byte-0 stop bit and the byte-1 start bit
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     rx     serial line, idle high, asynchronous to clk
//     bus    uart_rx_if.master: rx_data, rx_valid, rx_ack, frame_err,
//            timeout_err, overrun, busy
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx,
    uart_rx_if.master bus
);

    localparam int CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TMO_W     = $clog2(TMO_LIMIT + 1);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TMO_LIMIT);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Synchroniser
    logic rx_meta;
    logic rx_s;

    // Bit FSM
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             byte_good;
    logic             byte_bad;

    // Assembler and output
    logic             has_first_q;
    logic [7:0]       byte0_q;
    logic [TMO_W-1:0] tmo_q;
    logic             word_fire;
    logic [15:0]      rx_data_q;
    logic             rx_valid_q;
    logic             frame_err_q;
    logic             timeout_err_q;
    logic             overrun_q;

    // ---- stage: line synchroniser (both flops reset to the idle level) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // ---- stage: bit FSM ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // The shift register is pure data. The FSM qualifies every use of it.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        byte_good = 1'b0;
        byte_bad  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;          // glitch, not a real start bit
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[7:1]};   // LSB arrives first
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STOP: begin
                // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
                if (cnt_q == FULL_CNT) begin
                    cnt_d     = '0;
                    state_d   = IDLE;
                    byte_good = rx_s;
                    byte_bad  = !rx_s;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign word_fire = byte_good && has_first_q;

    // ---- stage: byte assembler and output handshake ----
    always_ff @(posedge clk) begin
        if (byte_good && !has_first_q) begin
            byte0_q <= shreg_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            has_first_q   <= 1'b0;
            tmo_q         <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;

            if (byte_bad) begin
                frame_err_q <= 1'b1;
                has_first_q <= 1'b0;
            end else if (byte_good) begin
                has_first_q <= !has_first_q;
                tmo_q       <= '0;
            end else if (has_first_q && (state_q == IDLE)) begin
                // The timeout counter only runs between bytes. It freezes while a byte is in flight.
                if (tmo_q == TMO_MAX) begin
                    timeout_err_q <= 1'b1;
                    has_first_q   <= 1'b0;
                    tmo_q         <= '0;
                end else begin
                    tmo_q <= tmo_q + TMO_ONE;
                end
            end

            // An ack in the same cycle frees the slot, so the new word loads without overrun.
            if (word_fire) begin
                if (!rx_valid_q || bus.rx_ack) begin
                    rx_data_q  <= {byte0_q, shreg_q};
                    rx_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && bus.rx_ack) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.overrun     = overrun_q;
    assign bus.busy        = (state_q != IDLE) || has_first_q;

endmodule
